// File: rtl/hub_pkg.sv
// Shared constants and message type for the hub-side router: FPGA IDs and
// the position of the destination-ID field in a message.
package hub_pkg;
  localparam logic [7:0] HUB_FPGA_ID  = 8'h00;
  localparam logic [7:0] BROADCAST_ID = 8'hFF;
  localparam int         ID_LSB       = 56;
  localparam int         ID_WIDTH     = 8;
  localparam int         MSG_WIDTH    = 64;

  typedef logic [MSG_WIDTH-1:0] msg_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: grants the first requester at or
// above ptr, wrapping around. The pointer register is owned by the caller.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  // NOTE: every output of a combinational block gets a default first so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    int  idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (en && !found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/fpga_hub_router.sv
// Hub-side router: routes single-beat host messages to leaf FPGAs by ID
// (with broadcast) and merges leaf messages round-robin onto one stream.
module fpga_hub_router
  import hub_pkg::*;
#(
  parameter int         NUM_CHILDREN = 4,
  parameter int         DATA_WIDTH   = 64,
  parameter int         ID_POS       = ID_LSB,
  parameter logic [7:0] BCAST_ID     = BROADCAST_ID
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [DATA_WIDTH-1:0]              host_rx_data,
  input  logic                               host_rx_valid,
  output logic                               host_rx_ready,
  output logic [DATA_WIDTH-1:0]              host_tx_data,
  output logic                               host_tx_valid,
  input  logic                               host_tx_ready,
  output logic [NUM_CHILDREN*DATA_WIDTH-1:0] child_tx_data,
  output logic [NUM_CHILDREN-1:0]            child_tx_valid,
  input  logic [NUM_CHILDREN-1:0]            child_tx_ready,
  input  logic [NUM_CHILDREN*DATA_WIDTH-1:0] child_rx_data,
  input  logic [NUM_CHILDREN-1:0]            child_rx_valid,
  output logic [NUM_CHILDREN-1:0]            child_rx_ready,
  output logic [7:0]                         drop_count,
  output logic                               router_busy
);

  localparam int PW = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1;

  // Downstream path
  logic [DATA_WIDTH-1:0]   down_data;
  logic [NUM_CHILDREN-1:0] down_mask;
  logic [NUM_CHILDREN-1:0] dec_mask;
  logic [7:0]              dest_id;
  logic                    down_accept;

  assign dest_id = host_rx_data[ID_POS +: 8];

  always_comb begin
    dec_mask = '0;
    for (int i = 0; i < NUM_CHILDREN; i++)
      dec_mask[i] = (dest_id == 8'(i + 1)) || (dest_id == BCAST_ID);
  end

  // Ready when every pending child is either done or accepting this cycle.
  assign host_rx_ready = ((down_mask & ~child_tx_ready) == '0);
  assign down_accept   = host_rx_valid && host_rx_ready;

  assign child_tx_valid = down_mask;
  assign child_tx_data  = {NUM_CHILDREN{down_data}};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      down_mask  <= '0;
      drop_count <= '0;
    end else begin
      if (down_accept) down_mask <= dec_mask;
      else             down_mask <= down_mask & ~child_tx_ready;
      if (down_accept && dec_mask == '0 && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
    end
  end

  // NOTE: payload registers carry no reset; their valid qualifiers are reset,
  // so stale contents are never observed and the data path stays reset-free.
  always_ff @(posedge clk) begin
    if (down_accept) down_data <= host_rx_data;
  end

  // Upstream path
  logic [PW-1:0]           rr_ptr;
  logic [NUM_CHILDREN-1:0] gnt;
  logic [PW-1:0]           gnt_idx;
  logic                    can_load;
  logic                    any_gnt;

  assign can_load = !host_tx_valid || host_tx_ready;

  rr_arbiter #(.N(NUM_CHILDREN), .PW(PW)) u_arb (
    .req     (child_rx_valid),
    .en      (can_load),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign child_rx_ready = gnt;
  assign any_gnt        = |gnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      host_tx_valid <= 1'b0;
      rr_ptr        <= '0;
    end else if (any_gnt) begin
      host_tx_valid <= 1'b1;
      rr_ptr        <= (gnt_idx == PW'(NUM_CHILDREN - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (host_tx_ready) begin
      host_tx_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (any_gnt) host_tx_data <= child_rx_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
  end

  assign router_busy = (|down_mask) || host_tx_valid || (|child_rx_valid);

endmodule

// File: tb/tb_fpga_hub_router.sv
// Directed self-checking bench for fpga_hub_router: unicast, broadcast with
// skew, drops with saturation, round-robin merge, backpressure, mid-broadcast reset.
module tb_fpga_hub_router;
  localparam int N = 4;
  localparam int W = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic [W-1:0]     host_rx_data;
  logic             host_rx_valid;
  logic             host_rx_ready;
  logic [W-1:0]     host_tx_data;
  logic             host_tx_valid;
  logic             host_tx_ready;
  logic [N*W-1:0]   child_tx_data;
  logic [N-1:0]     child_tx_valid;
  logic [N-1:0]     child_tx_ready;
  logic [N*W-1:0]   child_rx_data;
  logic [N-1:0]     child_rx_valid;
  logic [N-1:0]     child_rx_ready;
  logic [7:0]       drop_count;
  logic             router_busy;

  int n_cmp = 0;
  int n_err = 0;

  fpga_hub_router dut (
    .clk            (clk),
    .reset          (reset),
    .host_rx_data   (host_rx_data),
    .host_rx_valid  (host_rx_valid),
    .host_rx_ready  (host_rx_ready),
    .host_tx_data   (host_tx_data),
    .host_tx_valid  (host_tx_valid),
    .host_tx_ready  (host_tx_ready),
    .child_tx_data  (child_tx_data),
    .child_tx_valid (child_tx_valid),
    .child_tx_ready (child_tx_ready),
    .child_rx_data  (child_rx_data),
    .child_rx_valid (child_rx_valid),
    .child_rx_ready (child_rx_ready),
    .drop_count     (drop_count),
    .router_busy    (router_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge, then let outputs settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] child_word(int i);
    return 64'hC0C0_0000_0000_0000 | 64'(i) << 8 | 64'h11 * 64'(i + 1);
  endfunction

  logic [63:0] uni_a, uni_b, bcast, bad0, bad9;

  initial begin
    uni_a = 64'h02AA_AAAA_AAAA_AAAA;
    uni_b = 64'h0300_0000_0000_0055;
    bcast = 64'hFF12_3456_789A_BCDE;
    bad0  = 64'h0000_0000_0000_0001;
    bad9  = 64'h0900_0000_0000_0002;

    reset          = 1'b0;
    host_rx_data   = '0;
    host_rx_valid  = 1'b0;
    host_tx_ready  = 1'b0;
    child_tx_ready = '0;
    child_rx_valid = '0;
    for (int i = 0; i < N; i++) child_rx_data[i*W +: W] = child_word(i);

    step(); step();
    check("rst_child_tx_valid", 64'(child_tx_valid), 64'h0);
    check("rst_host_tx_valid",  64'(host_tx_valid), 64'h0);
    check("rst_child_rx_ready", 64'(child_rx_ready), 64'h0);
    check("rst_drop_count",     64'(drop_count), 64'h0);
    check("rst_host_rx_ready",  64'(host_rx_ready), 64'h1);
    reset = 1'b1;

    // 1. Unicast to ID 2, then ID 3 back-to-back
    step();
    child_tx_ready = 4'b1111;
    host_rx_data   = uni_a;
    host_rx_valid  = 1'b1;
    #1;
    check("uni_ready_a", 64'(host_rx_ready), 64'h1);
    step();
    check("uni_valid_a", 64'(child_tx_valid), 64'b0010);
    check("uni_data_a",  child_tx_data[1*W +: W], uni_a);
    host_rx_data = uni_b;
    #1;
    check("uni_ready_b", 64'(host_rx_ready), 64'h1);
    step();
    check("uni_valid_b", 64'(child_tx_valid), 64'b0100);
    check("uni_data_b",  child_tx_data[2*W +: W], uni_b);
    host_rx_valid = 1'b0;
    step();
    check("uni_idle", 64'(child_tx_valid), 64'h0);

    // 2. Broadcast with skewed child acceptance
    child_tx_ready = 4'b0001;
    host_rx_data   = bcast;
    host_rx_valid  = 1'b1;
    step();
    host_rx_valid = 1'b0;
    #1;
    check("bc_valid_c1", 64'(child_tx_valid), 64'b1111);
    check("bc_ready_c1", 64'(host_rx_ready), 64'h0);
    check("bc_data3",    child_tx_data[3*W +: W], bcast);
    step();
    check("bc_valid_c2", 64'(child_tx_valid), 64'b1110);
    child_tx_ready = 4'b1110;
    #1;
    check("bc_ready_c2", 64'(host_rx_ready), 64'h1);
    step();
    check("bc_done",    64'(child_tx_valid), 64'h0);
    check("bc_ready",   64'(host_rx_ready), 64'h1);
    check("bc_busy",    64'(router_busy), 64'h0);

    // 3. Invalid IDs are dropped and counted, saturating at 255
    child_tx_ready = 4'b1111;
    host_rx_data   = bad0;
    host_rx_valid  = 1'b1;
    step();
    check("drop0_valid", 64'(child_tx_valid), 64'h0);
    check("drop0_count", 64'(drop_count), 64'd1);
    host_rx_data = bad9;
    step();
    check("drop9_valid", 64'(child_tx_valid), 64'h0);
    check("drop9_count", 64'(drop_count), 64'd2);
    for (int k = 0; k < 300; k++) step();
    host_rx_valid = 1'b0;
    step();
    check("drop_sat", 64'(drop_count), 64'd255);

    // 4. Round-robin merge, all children valid, host always ready
    host_tx_ready  = 1'b1;
    child_rx_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("rr_gnt%0d", k), 64'(child_rx_ready), 64'(1) << (k % N));
      step();
      check($sformatf("rr_valid%0d", k), 64'(host_tx_valid), 64'h1);
      check($sformatf("rr_data%0d", k), host_tx_data, child_word(k % N));
    end
    child_rx_valid = '0;
    step();
    check("rr_drain", 64'(host_tx_valid), 64'h0);

    // 5. Backpressure: one load, then stall with data held (rr_ptr is 1 here)
    host_tx_ready  = 1'b0;
    child_rx_valid = 4'b1000;
    #1;
    check("bp_gnt", 64'(child_rx_ready), 64'b1000);
    step();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_hold_rdy%0d", k), 64'(child_rx_ready), 64'h0);
      check($sformatf("bp_hold_dat%0d", k), host_tx_data, child_word(3));
      check($sformatf("bp_hold_vld%0d", k), 64'(host_tx_valid), 64'h1);
      step();
    end
    host_tx_ready  = 1'b1;
    child_rx_valid = '0;
    step();
    check("bp_release", 64'(host_tx_valid), 64'h0);

    // 6. Reset in the middle of a broadcast after 2 of 4 children accepted
    child_tx_ready = 4'b0011;
    host_rx_data   = bcast;
    host_rx_valid  = 1'b1;
    step();
    host_rx_valid = 1'b0;
    step();
    check("mid_bc_mask", 64'(child_tx_valid), 64'b1100);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 64'(child_tx_valid), 64'h0);
    check("mid_rst_drop",  64'(drop_count), 64'h0);
    check("mid_rst_htx",   64'(host_tx_valid), 64'h0);
    step();
    reset          = 1'b1;
    child_tx_ready = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("post_rst_valid%0d", k), 64'(child_tx_valid), 64'h0);
    end
    check("post_rst_busy", 64'(router_busy), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
